// File: rtl/uart_rx_controller.sv
// UART receiver for a same-clock-domain serial link: one line bit per clk edge,
// start/data/stop framing with a single-entry holding register and valid/ready handoff.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a 0 (start bit)
// DATA   | sampling data bits LSB first, one per edge
// STOP   | sampling the stop bit; 1 = good frame, 0 = framing error
// BREAK  | line held low after a bad stop bit; wait for it to return high
module uart_rx_controller #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_active,
  output logic                 rx_framing_err,
  output logic                 rx_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STOP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  // Counter is 3 bits because DATA_BITS never exceeds 8.
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    // A completing frame below may override this consume.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_in) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        shift_d[bit_cnt_q] = rx_in;
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = S_STOP;
          bit_cnt_d = 3'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_in) begin
          state_d = S_IDLE;
          if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          state_d = S_BREAK;
          ferr_d  = 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data        = data_q;
  assign rx_valid       = valid_q;
  assign rx_active      = (state_q == S_DATA) || (state_q == S_STOP);
  assign rx_framing_err = ferr_q;
  assign rx_overrun     = ovr_q;

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame, legal range 5..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port rx_in, input, 1, serial line, one bit per clk, idle high, driven by the TX controller's serial output in the same clock domain.
REQ-005 The block SHALL have port rx_data, output, DATA_BITS, received byte with bit 0 first on the line.
REQ-006 The block SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-007 The block SHALL have port rx_ready, input, 1, consumer accepts rx_data when rx_valid and rx_ready are both high at a rising edge.
REQ-008 The block SHALL have port rx_active, output, 1, high while a frame is being received (DATA and STOP states).
REQ-009 The block SHALL have port rx_framing_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port rx_overrun, output, 1, one-cycle pulse when a good frame is dropped.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, DATA, STOP and BREAK, all registered.
REQ-012 In IDLE, rx_in=0 sampled at an edge SHALL move the FSM to DATA with bit counter 0; rx_in=1 SHALL keep it in IDLE.
REQ-013 In DATA, each edge SHALL sample rx_in into shift position bit counter, LSB first, and increment the counter.
REQ-014 At the edge that samples bit DATA_BITS-1, the FSM SHALL move to STOP and clear the counter.
REQ-015 In STOP, rx_in=1 SHALL mark the frame good and move to IDLE.
REQ-016 In STOP, rx_in=0 SHALL discard the frame, pulse rx_framing_err in the next cycle and move to BREAK.
REQ-017 BREAK SHALL hold until rx_in=1 is sampled, then move to IDLE; a 0 in BREAK SHALL NOT start a frame.
REQ-018 For DATA_BITS=8, with the start bit sampled at edge N, data SHALL be sampled at edges N+1..N+8 and the stop bit at N+9; rx_valid and rx_data SHALL update at edge N+9.
REQ-019 A start bit SHALL be accepted at the edge immediately after the STOP-sampling edge, so back-to-back frames incur no dead cycle.
REQ-020 A good frame SHALL load the holding register when rx_valid=0, or when rx_valid=1 and rx_ready=1 at the same edge; rx_valid SHALL then be 1.
REQ-021 A good frame arriving with rx_valid=1 and rx_ready=0 SHALL be dropped, rx_data and rx_valid SHALL stay unchanged, and rx_overrun SHALL pulse for one cycle.
REQ-022 A handshake with no frame completing at that edge SHALL clear rx_valid; rx_data SHALL keep its last value.
REQ-023 rx_data SHALL be stable while rx_valid=1 and not consumed.
REQ-024 rx_framing_err and rx_overrun SHALL never exceed one cycle per frame and SHALL NOT both be high at once.
REQ-025 rx_active SHALL be 1 exactly when the registered state is DATA or STOP.

Reset
REQ-026 On reset_n low, independent of clk, the block SHALL force state IDLE, bit counter 0, rx_data 0, rx_valid 0, rx_active 0, rx_framing_err 0 and rx_overrun 0.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame with no flag raised.
REQ-028 After reset_n rises, the first 0 sampled on rx_in SHALL be treated as a start bit.

Verification
REQ-029 The bench SHALL cover: TX controller sends 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid high for one cycle at edge N+9, no flags.
REQ-030 The bench SHALL cover: back-to-back 0x3C then 0xC3 with rx_ready=0 and no read between them -> rx_data stays 0x3C, rx_overrun pulses once at the second stop bit, rx_valid stays 1.
REQ-031 The bench SHALL cover: same as REQ-030 but rx_ready=1 at the second completion edge -> rx_data=0xC3, rx_valid stays 1, no overrun.
REQ-032 The bench SHALL cover: frame 0x55 with the stop bit forced 0, then line held 0 for 5 cycles, then 1 -> rx_framing_err pulses once, rx_valid stays 0, no new frame until the line returns to 1 and falls again.
REQ-033 The bench SHALL cover: reset_n pulsed low at data bit 4 of 0xFF -> all outputs 0 immediately; the next frame 0x01 is received correctly.
REQ-034 The bench SHALL cover: DATA_BITS=5 with frame 0x15 -> rx_data=0x15 with valid asserted at edge N+6.
